pair_splitter: RTL and testbench

Upstream feeder for the modular adder pipeline. Accepts one AXI-stream of operand words, de-interleaves them into even/odd pairs on two output channels (channel 0 = a, channel 1 = b) and reduces each word into [0, P) before buffering. Output buffering is per channel, so the adder can pop both channels in the same cycle. A word stream with an odd count is closed with s_tlast, and the missing partner is zero-padded.

---
 rtl/pair_splitter.sv | 115 +++++++++++
 tb/tb_pair_splitter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pair_splitter.sv
// De-interleaves an operand stream into a/b channels, each with its own FIFO.
// Define PAIR_SPLITTER_REDUCE_EN to reduce each word into [0, P) with one conditional subtract.
`timescale 1ns/1ps
module pair_splitter #(
    parameter int P            = 100,
    parameter int BITS         = $clog2(P),
    parameter int C_DATA_WIDTH = 32,
    parameter int DEPTH        = 4
) (
    input  logic                         aclk,
    input  logic                         areset,
    input  logic                         s_tvalid,
    input  logic [C_DATA_WIDTH-1:0]      s_tdata,
    input  logic                         s_tlast,
    output logic                         s_tready,
    output logic [1:0]                   m_tvalid,
    output logic [1:0][C_DATA_WIDTH-1:0] m_tdata,
    input  logic [1:0]                   m_tready,
    output logic [31:0]                  pair_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic            sel;
    logic [AW:0]     count  [2];
    logic [AW-1:0]   wr_ptr [2];
    logic [AW-1:0]   rd_ptr [2];
    logic [BITS-1:0] mem    [2][DEPTH];
    logic [BITS-1:0] wr_data[2];
    logic [BITS-1:0] reduced;
    logic [1:0]      full;
    logic [1:0]      wr;
    logic [1:0]      pop;
    logic            accept;

`ifdef PAIR_SPLITTER_REDUCE_EN
    logic [BITS-1:0] diff;

    // Subtracting in BITS width gives (d - P) mod 2^BITS directly.
    always_comb begin
        diff    = s_tdata[BITS-1:0] - BITS'(P);
        reduced = (s_tdata >= C_DATA_WIDTH'(P)) ? diff : s_tdata[BITS-1:0];
    end
`else
    logic unused_hi;

    assign unused_hi = ^s_tdata[C_DATA_WIDTH-1:BITS];

    always_comb begin
        reduced = s_tdata[BITS-1:0];
    end
`endif

    always_comb begin
        full = '0;
        pop  = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            full[i]     = (count[i] == FULL_CNT);
            m_tvalid[i] = (count[i] != '0);
            pop[i]      = m_tvalid[i] && m_tready[i];
            m_tdata[i]  = m_tvalid[i] ? C_DATA_WIDTH'(mem[i][rd_ptr[i]]) : '0;
        end
    end

    // Readiness uses only registered counts; a pad beat needs room in both channels.
    always_comb begin
        if (areset)
            s_tready = 1'b0;
        else if (sel)
            s_tready = !full[1];
        else if (s_tlast)
            s_tready = !full[0] && !full[1];
        else
            s_tready = !full[0];
        accept     = s_tvalid && s_tready;
        wr[0]      = accept && !sel;
        wr[1]      = accept && (sel || s_tlast);
        wr_data[0] = reduced;
        wr_data[1] = sel ? reduced : '0;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            sel      <= 1'b0;
            pair_cnt <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                count[i]  <= '0;
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
        end else begin
            if (accept)
                sel <= ~sel & ~s_tlast;
            if (wr[1])
                pair_cnt <= pair_cnt + 32'd1;
            for (int unsigned i = 0; i < 2; i++) begin
                if (wr[i])
                    wr_ptr[i] <= wr_ptr[i] + AW'(1);
                if (pop[i])
                    rd_ptr[i] <= rd_ptr[i] + AW'(1);
                if (wr[i] && !pop[i])
                    count[i] <= count[i] + (AW+1)'(1);
                else if (!wr[i] && pop[i])
                    count[i] <= count[i] - (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge aclk) begin
        for (int unsigned i = 0; i < 2; i++) begin
            if (wr[i])
                mem[i][wr_ptr[i]] <= wr_data[i];
        end
    end
endmodule

// File: tb/tb_pair_splitter.sv
// Bench for pair_splitter: directed scenarios plus random traffic against a queue-based model.
`timescale 1ns/1ps
module tb_pair_splitter;
    localparam int P     = 100;
    localparam int BITS  = $clog2(P);
    localparam int W     = 32;
    localparam int DEPTH = 4;

    logic                aclk     = 1'b0;
    logic                areset   = 1'b1;
    logic                s_tvalid = 1'b0;
    logic [W-1:0]        s_tdata  = '0;
    logic                s_tlast  = 1'b0;
    logic                s_tready;
    logic [1:0]          m_tvalid;
    logic [1:0][W-1:0]   m_tdata;
    logic [1:0]          m_tready = '0;
    logic [31:0]         pair_cnt;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int unsigned data;
        bit          last;
    } beat_t;

    beat_t       pend[$];
    int unsigned q0[$];
    int unsigned q1[$];
    bit          odd_m;
    int unsigned pairs_m;
    bit          gaps;

    pair_splitter #(
        .P            (P),
        .BITS         (BITS),
        .C_DATA_WIDTH (W),
        .DEPTH        (DEPTH)
    ) dut (
        .aclk     (aclk),
        .areset   (areset),
        .s_tvalid (s_tvalid),
        .s_tdata  (s_tdata),
        .s_tlast  (s_tlast),
        .s_tready (s_tready),
        .m_tvalid (m_tvalid),
        .m_tdata  (m_tdata),
        .m_tready (m_tready),
        .pair_cnt (pair_cnt)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int unsigned red(input int unsigned d);
`ifdef PAIR_SPLITTER_REDUCE_EN
        if (d >= P)
            return (d - P) % (1 << BITS);
`endif
        return d % (1 << BITS);
    endfunction

    // odd_m: an unpaired word is waiting for its partner on channel b.
    function automatic bit exp_ready(input bit last);
        if (odd_m)
            return q1.size() < DEPTH;
        if (last)
            return (q0.size() < DEPTH) && (q1.size() < DEPTH);
        return q0.size() < DEPTH;
    endfunction

    task automatic push(input int unsigned d, input bit last);
        beat_t b;
        b.data = d;
        b.last = last;
        pend.push_back(b);
    endtask

    task automatic step(input logic [1:0] rdy);
        bit          er;
        bit          acc;
        bit          lst;
        bit [1:0]    pops;
        int unsigned d;
        m_tready = rdy;
        if (!s_tvalid && pend.size() != 0 && (!gaps || $urandom_range(3) != 0)) begin
            s_tvalid = 1'b1;
            s_tdata  = pend[0].data;
            s_tlast  = pend[0].last;
        end
        #1;
        er = exp_ready(s_tlast);
        check("s_tready", s_tready, er);
        check("m_tvalid", m_tvalid, {q1.size() != 0, q0.size() != 0});
        check("m_tdata0", m_tdata[0], q0.size() != 0 ? q0[0] : 0);
        check("m_tdata1", m_tdata[1], q1.size() != 0 ? q1[0] : 0);
        check("pair_cnt", pair_cnt, pairs_m);
        acc  = s_tvalid && er;
        lst  = s_tlast;
        d    = s_tdata;
        pops = {rdy[1] && q1.size() != 0, rdy[0] && q0.size() != 0};
        @(posedge aclk);
        if (pops[0]) void'(q0.pop_front());
        if (pops[1]) void'(q1.pop_front());
        if (acc) begin
            if (!odd_m) begin
                q0.push_back(red(d));
                if (lst) begin
                    q1.push_back(0);
                    pairs_m++;
                end else begin
                    odd_m = 1'b1;
                end
            end else begin
                q1.push_back(red(d));
                pairs_m++;
                odd_m = 1'b0;
            end
            void'(pend.pop_front());
        end
        #1;
        if (acc) begin
            s_tvalid = 1'b0;
            s_tlast  = 1'b0;
        end
        @(negedge aclk);
    endtask

    task automatic run(input int n, input logic [1:0] rdy);
        for (int i = 0; i < n; i++)
            step(rdy);
    endtask

    task automatic do_reset();
        areset   = 1'b1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        pend.delete();
        #1;
        check("rst_s_tready", s_tready, 0);
        @(posedge aclk);
        q0.delete();
        q1.delete();
        odd_m   = 1'b0;
        pairs_m = 0;
        @(negedge aclk);
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_tdata", m_tdata, 0);
        check("rst_pair_cnt", pair_cnt, 0);
        check("rst_s_tready_hold", s_tready, 0);
        areset = 1'b0;
        #1;
        check("post_rst_s_tready", s_tready, 1);
    endtask

    initial begin
        gaps = 1'b0;
        do_reset();

        // Basic pairing
        push(5, 0); push(7, 0); push(40, 0); push(60, 1);
        run(8, 2'b11);
        check("basic_pairs", pair_cnt, 2);

        // Reduction boundary values
        push(150, 0); push(99, 0); push(100, 0); push(0, 1);
        run(4, 2'b00);
`ifdef PAIR_SPLITTER_REDUCE_EN
        check("red_ch0_head", m_tdata[0], 50);
`else
        check("red_ch0_head", m_tdata[0], 22);
`endif
        check("red_ch1_head", m_tdata[1], 99);
        run(8, 2'b11);

        // Odd stream closed by tlast, then next word must go to channel a
        push(3, 0); push(4, 0); push(9, 1);
        run(3, 2'b00);
        check("pad_pairs", pair_cnt, 6);
        check("pad_ch1_count", m_tvalid, 2'b11);
        push(11, 0);
        run(1, 2'b00);
        push(12, 1);
        run(10, 2'b11);

        // Back-pressure: both FIFOs fill after 8 words
        for (int unsigned i = 0; i < 10; i++)
            push(20 + i, i == 9);
        run(12, 2'b00);
        check("bp_ready_low", s_tready, 0);
        check("bp_stall_pairs", pair_cnt, 11);
        run(20, 2'b11);
        check("bp_final_pairs", pair_cnt, 12);

        // Skewed pops: only channel a drains
        for (int unsigned i = 0; i < 6; i++)
            push(30 + i, i == 5);
        run(6, 2'b00);
        run(3, 2'b01);
        check("skew_valid", m_tvalid, 2'b10);
        check("skew_ch1_head", m_tdata[1], 31);
        run(8, 2'b11);

        // Reset after an odd number of words
        push(41, 0); push(42, 0); push(43, 0);
        run(3, 2'b11);
        do_reset();
        push(44, 0);
        run(1, 2'b00);
        check("rst_route_valid", m_tvalid, 2'b01);
        check("rst_route_data", m_tdata[0], 44);
        push(45, 1);
        run(4, 2'b11);

        // Random traffic
        gaps = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (pend.size() < 3 && $urandom_range(1) == 1) begin
`ifdef PAIR_SPLITTER_REDUCE_EN
                push($urandom_range(2 * P - 1), $urandom_range(4) == 0);
`else
                push($urandom_range(P - 1), $urandom_range(4) == 0);
`endif
            end
            step(2'($urandom_range(3)));
        end
        gaps = 1'b0;
        run(30, 2'b11);
        check("final_empty", m_tvalid, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
